command_dbuf: RTL and testbench
===============================

# command_dbuf

Parametrised command-layer controller for the SATA host. It turns single-cycle application command requests into a handshaked command to the transport layer and tracks that command to completion. It also buffers transport-layer read data in a depth-configurable FIFO with back-pressure, a last-word marker and overflow detection. It sits between the application-layer register interface and the transport layer.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 10, buffer address width; depth = 2^ADDR_W words
- TYPE_W, 3, command type width
- PORT_W, 4, port multiplier field width
- AF_MARGIN, 4, free-word margin at which tl_data_busy_out asserts (1..2^ADDR_W-1)
- TO_W, 16, timeout counter width (used only with CMD_DBUF_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- al_cmd_val_in  in  1  command request strobe
- al_cmd_type_in  in  TYPE_W  command type, sampled with strobe
- al_cmd_port_in  in  PORT_W  port, sampled with strobe
- al_cmd_abort_in  in  1  abort the outstanding command
- al_ack_in  in  1  acknowledge completion, clears done flags
- al_flush_in  in  1  empty the buffer
- al_busy_out  out  1  FSM not IDLE
- al_done_good_out  out  1  sticky, command completed good
- al_done_bad_out  out  1  sticky, command failed, aborted or timed out
- al_timeout_out  out  1  sticky, timeout cause (0 when macro off)
- cmd_type  out  TYPE_W  latched type
- cmd_port  out  PORT_W  latched port
- cmd_val  out  1  command valid to TL
- cmd_busy  in  1  TL cannot accept
- cmd_done_good, cmd_done_bad  in  1  TL completion pulses
- tl_data_in  in  DATA_W  read data from TL
- tl_data_val_in  in  1  write strobe
- tl_data_last_in  in  1  last word of transfer
- tl_data_busy_out  out  1  back-pressure to TL
- al_data_strobe_in  in  1  pop request
- al_data_out  out  DATA_W  popped word
- al_data_val_out  out  1  al_data_out valid
- al_data_last_out  out  1  popped word carried last
- al_fill_out  out  ADDR_W+1  words stored
- al_overflow_out  out  1  sticky, word dropped on full

## Operation
- FSM has four states.
  - IDLE: al_cmd_val_in latches type/port, clears overflow → ISSUE. Strobe in any other state is ignored.
  - ISSUE: cmd_val = ~cmd_busy; when cmd_val is 1 the command is accepted that cycle → WAIT.
  - WAIT: cmd_done_good → DONE with done_good=1; cmd_done_bad → DONE with done_bad=1. If both are high, bad wins.
  - DONE: flags held; al_ack_in clears all flags → IDLE.
- Abort in ISSUE or WAIT → DONE with done_bad=1. Abort has priority over TL done in the same cycle. Abort in IDLE or DONE is ignored.
- Buffer write: occurs when tl_data_val_in & fill<2^ADDR_W; stores {last,data}. When full, the word is dropped and al_overflow_out is set.
- Buffer read: al_data_strobe_in & fill>0 pops. A strobe when empty is ignored and produces no valid.
- Simultaneous push and pop: fill unchanged, pointers wrap modulo 2^ADDR_W. A pop and a push on a buffer that is full at that edge are both performed.
- Flush clears pointers and fill. It wins over a same-cycle push (word discarded) and a same-cycle pop (no valid).
- tl_data_busy_out = (fill ≥ 2^ADDR_W − AF_MARGIN), registered from post-update fill.
- Reset (any time, including mid-command or mid-transfer): IDLE, pointers/fill 0, all flags 0. Buffer contents are undefined and unreadable.

## Timing
- Reset values: every output 0 except al_data_out, which is undefined until the first valid.
- cmd_val is combinational from state and cmd_busy. It asserts the cycle after the accepted al_cmd_val_in if cmd_busy=0.
- Done flags and al_busy_out are registered and change the cycle after the causing event. al_busy_out drops the cycle after al_ack_in.
- Read latency is 1: al_data_val_out/al_data_last_out/al_data_out update the cycle after the popping strobe. al_data_val_out is a one-cycle pulse per pop.
- al_fill_out and al_overflow_out are registered and reflect the edge's push/pop/flush the next cycle.
- Back-to-back pops on consecutive cycles are supported at full rate.

## Configuration
- CMD_DBUF_TIMEOUT_EN defined: a TO_W counter runs in WAIT and is cleared on entering WAIT. When it reaches 2^TO_W−1 without a TL done, the FSM goes to DONE with done_bad=1 and al_timeout_out=1. A TL done on the terminal cycle wins over the timeout (no timeout flag).
- Undefined: no counter, al_timeout_out tied 0, and WAIT waits indefinitely.

## Test plan
- Command good path, cmd_busy=1 for 3 cycles: al_cmd_val_in with type 3'h2, port 4'h5 → cmd_val held low 3 cycles, then one pulse with cmd_type=2, cmd_port=5; cmd_done_good → al_done_good_out=1 next cycle; al_ack_in → IDLE, flags 0.
- Abort and TL done_bad in the same WAIT cycle → done_bad=1, done_good=0. A second al_cmd_val_in while in DONE is ignored.
- ADDR_W=4, AF_MARGIN=4: 12 pushes → tl_data_busy_out=1; 17 pushes total → fill=16, overflow=1, the 17th word is absent on readout. 16 pops return words 0..15 in order, each 1 cycle after its strobe.
- Full buffer, simultaneous push+pop → fill stays 16, no overflow; the pushed word is read last with last=1 when tl_data_last_in was set.
- Flush coinciding with a push at fill=5 → fill=0. A pop strobe on the next cycle gives no al_data_val_out.
- With CMD_DBUF_TIMEOUT_EN, TO_W=4: no TL done for 15 WAIT cycles → done_bad=1, al_timeout_out=1. Reset asserted mid-WAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/command_dbuf.sv
// SATA host command-layer controller with a read-data FIFO toward the application layer.
// Define CMD_DBUF_TIMEOUT_EN to abort commands whose transport completion never arrives.
module command_dbuf #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned TYPE_W    = 3,
  parameter int unsigned PORT_W    = 4,
  parameter int unsigned AF_MARGIN = 4,
  parameter int unsigned TO_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              al_cmd_val_in,
  input  logic [TYPE_W-1:0] al_cmd_type_in,
  input  logic [PORT_W-1:0] al_cmd_port_in,
  input  logic              al_cmd_abort_in,
  input  logic              al_ack_in,
  input  logic              al_flush_in,
  output logic              al_busy_out,
  output logic              al_done_good_out,
  output logic              al_done_bad_out,
  output logic              al_timeout_out,
  output logic [TYPE_W-1:0] cmd_type,
  output logic [PORT_W-1:0] cmd_port,
  output logic              cmd_val,
  input  logic              cmd_busy,
  input  logic              cmd_done_good,
  input  logic              cmd_done_bad,
  input  logic [DATA_W-1:0] tl_data_in,
  input  logic              tl_data_val_in,
  input  logic              tl_data_last_in,
  output logic              tl_data_busy_out,
  input  logic              al_data_strobe_in,
  output logic [DATA_W-1:0] al_data_out,
  output logic              al_data_val_out,
  output logic              al_data_last_out,
  output logic [ADDR_W:0]   al_fill_out,
  output logic              al_overflow_out
);

  localparam int unsigned Depth   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DepthW  = (ADDR_W+1)'(Depth);
  localparam logic [ADDR_W:0] AfLevel = (ADDR_W+1)'(Depth - AF_MARGIN);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic [PORT_W-1:0] port_q, port_d;
  logic              good_q, good_d, bad_q, bad_d, tout_q, tout_d;
  logic              cmd_accept;
  logic              to_hit;

`ifdef CMD_DBUF_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;

  assign to_hit = (cnt_q == {TO_W{1'b1}});
  // Counter is zero on the first WAIT cycle and only advances while waiting.
  assign cnt_d  = (state_q == StWait) ? cnt_q + TO_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic [TO_W-1:0] unused_to;
  assign unused_to = '0;
  assign to_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    port_d     = port_q;
    good_d     = good_q;
    bad_d      = bad_q;
    tout_d     = tout_q;
    cmd_accept = 1'b0;
    case (state_q)
      StIdle: begin
        if (al_cmd_val_in) begin
          type_d     = al_cmd_type_in;
          port_d     = al_cmd_port_in;
          cmd_accept = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (al_cmd_abort_in) begin
          bad_d   = 1'b1;
          state_d = StDone;
        end else if (!cmd_busy) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Abort beats TL completion; bad beats good; any completion beats timeout.
        if (al_cmd_abort_in || cmd_done_bad) begin
          bad_d   = 1'b1;
          state_d = StDone;
        end else if (cmd_done_good) begin
          good_d  = 1'b1;
          state_d = StDone;
        end else if (to_hit) begin
          bad_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (al_ack_in) begin
          good_d  = 1'b0;
          bad_d   = 1'b0;
          tout_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmd_val          = (state_q == StIssue) & ~cmd_busy;
  assign al_busy_out      = (state_q != StIdle);
  assign al_done_good_out = good_q;
  assign al_done_bad_out  = bad_q;
  assign al_timeout_out   = tout_q;
  assign cmd_type         = type_q;
  assign cmd_port         = port_q;

  // Read-data FIFO
  logic [DATA_W:0]   mem_q [Depth];
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              ovf_q, ovf_d, af_q, rd_val_q, rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              full, push, pop, drop;

  assign full = (fill_q == DepthW);
  assign pop  = al_data_strobe_in & (fill_q != '0) & ~al_flush_in;
  // A pop frees the slot the same-edge push lands in, so full does not block it.
  assign push = tl_data_val_in & (~full | pop) & ~al_flush_in;
  assign drop = tl_data_val_in & full & ~pop & ~al_flush_in;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (al_flush_in) begin
      wptr_d = '0;
      rptr_d = '0;
      fill_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + ADDR_W'(1);
      if (pop)  rptr_d = rptr_q + ADDR_W'(1);
      if (push && !pop)      fill_d = fill_q + (ADDR_W+1)'(1);
      else if (pop && !push) fill_d = fill_q - (ADDR_W+1)'(1);
    end
    ovf_d     = (cmd_accept ? 1'b0 : ovf_q) | drop;
    rd_last_d = pop & mem_q[rptr_q][DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      type_q    <= '0;
      port_q    <= '0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      tout_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fill_q    <= '0;
      ovf_q     <= 1'b0;
      af_q      <= 1'b0;
      rd_val_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      port_q    <= port_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      tout_q    <= tout_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fill_q    <= fill_d;
      ovf_q     <= ovf_d;
      af_q      <= (fill_d >= AfLevel);
      rd_val_q  <= pop;
      rd_last_q <= rd_last_d;
    end
  end

  // Storage and read data carry no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {tl_data_last_in, tl_data_in};
    if (pop)  rd_data_q     <= mem_q[rptr_q][DATA_W-1:0];
  end

  assign tl_data_busy_out = af_q;
  assign al_data_out      = rd_data_q;
  assign al_data_val_out  = rd_val_q;
  assign al_data_last_out = rd_last_q;
  assign al_fill_out      = fill_q;
  assign al_overflow_out  = ovf_q;

endmodule

// File: tb/tb_command_dbuf.sv
// Bench for command_dbuf: directed command scenarios plus a random FIFO run scored
// against a queue model; a separate monitor checks every read response.
module tb_command_dbuf;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int Depth = 16;
  localparam int Af = 4;

  logic clk, rst;
  logic al_cmd_val_in, al_cmd_abort_in, al_ack_in, al_flush_in;
  logic [2:0] al_cmd_type_in;
  logic [3:0] al_cmd_port_in;
  logic al_busy_out, al_done_good_out, al_done_bad_out, al_timeout_out;
  logic [2:0] cmd_type;
  logic [3:0] cmd_port;
  logic cmd_val, cmd_busy, cmd_done_good, cmd_done_bad;
  logic [DW-1:0] tl_data_in, al_data_out;
  logic tl_data_val_in, tl_data_last_in, tl_data_busy_out;
  logic al_data_strobe_in, al_data_val_out, al_data_last_out, al_overflow_out;
  logic [AW:0] al_fill_out;

  command_dbuf #(
    .DATA_W(DW), .ADDR_W(AW), .TYPE_W(3), .PORT_W(4), .AF_MARGIN(Af), .TO_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .al_cmd_val_in(al_cmd_val_in), .al_cmd_type_in(al_cmd_type_in),
    .al_cmd_port_in(al_cmd_port_in), .al_cmd_abort_in(al_cmd_abort_in),
    .al_ack_in(al_ack_in), .al_flush_in(al_flush_in),
    .al_busy_out(al_busy_out), .al_done_good_out(al_done_good_out),
    .al_done_bad_out(al_done_bad_out), .al_timeout_out(al_timeout_out),
    .cmd_type(cmd_type), .cmd_port(cmd_port), .cmd_val(cmd_val), .cmd_busy(cmd_busy),
    .cmd_done_good(cmd_done_good), .cmd_done_bad(cmd_done_bad),
    .tl_data_in(tl_data_in), .tl_data_val_in(tl_data_val_in),
    .tl_data_last_in(tl_data_last_in), .tl_data_busy_out(tl_data_busy_out),
    .al_data_strobe_in(al_data_strobe_in), .al_data_out(al_data_out),
    .al_data_val_out(al_data_val_out), .al_data_last_out(al_data_last_out),
    .al_fill_out(al_fill_out), .al_overflow_out(al_overflow_out)
  );

  typedef struct {
    int unsigned cyc;
    logic [DW:0] w;
  } exp_t;

  int checks = 0;
  int fails = 0;
  int unsigned cyc = 0;
  exp_t sb[$];
  logic [DW:0] mq[$];
  bit movf = 0;
  exp_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-response monitor: each pop is owed exactly one valid on its tagged cycle.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      chk("rd_val", al_data_val_out, 1);
      chk("rd_data", al_data_out, mon_e.w[DW-1:0]);
      chk("rd_last", al_data_last_out, mon_e.w[DW]);
    end else begin
      chk("rd_val_idle", al_data_val_out, 0);
    end
  end

  task automatic buf_step(input bit v, input logic [DW-1:0] d, input bit l, input bit s,
                          input bit f);
    exp_t e;
    tl_data_val_in = v;
    tl_data_in = d;
    tl_data_last_in = l;
    al_data_strobe_in = s;
    al_flush_in = f;
    if (f) begin
      mq.delete();
    end else begin
      if (s && mq.size() > 0) begin
        e.cyc = cyc + 1;
        e.w = mq.pop_front();
        sb.push_back(e);
      end
      if (v) begin
        if (mq.size() < Depth) mq.push_back({l, d});
        else movf = 1;
      end
    end
    tick();
    tl_data_val_in = 0;
    tl_data_last_in = 0;
    al_data_strobe_in = 0;
    al_flush_in = 0;
    chk("fill", al_fill_out, mq.size());
    chk("tl_busy", tl_data_busy_out, mq.size() >= Depth - Af);
    chk("overflow", al_overflow_out, movf);
  endtask

  // Issue a command, abort it in WAIT and acknowledge; the strobe clears overflow.
  task automatic cmd_abort_cycle();
    al_cmd_val_in = 1;
    tick();
    al_cmd_val_in = 0;
    movf = 0;
    tick();
    al_cmd_abort_in = 1;
    tick();
    al_cmd_abort_in = 0;
    chk("abort_bad", al_done_bad_out, 1);
    al_ack_in = 1;
    tick();
    al_ack_in = 0;
    chk("abort_ack_busy", al_busy_out, 0);
    chk("ovf_cleared", al_overflow_out, movf);
  endtask

  initial begin
    int lat;
    rst = 1;
    {al_cmd_val_in, al_cmd_abort_in, al_ack_in, al_flush_in} = '0;
    al_cmd_type_in = '0;
    al_cmd_port_in = '0;
    {cmd_busy, cmd_done_good, cmd_done_bad} = '0;
    tl_data_in = '0;
    {tl_data_val_in, tl_data_last_in, al_data_strobe_in} = '0;
    tick();
    tick();
    rst = 0;
    chk("rst_busy", al_busy_out, 0);
    chk("rst_good", al_done_good_out, 0);
    chk("rst_bad", al_done_bad_out, 0);
    chk("rst_tout", al_timeout_out, 0);
    chk("rst_cmd_val", cmd_val, 0);
    chk("rst_type", cmd_type, 0);
    chk("rst_port", cmd_port, 0);
    chk("rst_tl_busy", tl_data_busy_out, 0);
    chk("rst_last", al_data_last_out, 0);
    chk("rst_fill", al_fill_out, 0);
    chk("rst_ovf", al_overflow_out, 0);

    // Good path with three busy cycles
    cmd_busy = 1;
    al_cmd_val_in = 1;
    al_cmd_type_in = 3'h2;
    al_cmd_port_in = 4'h5;
    tick();
    al_cmd_val_in = 0;
    al_cmd_type_in = 0;
    al_cmd_port_in = 0;
    chk("c1_busy", al_busy_out, 1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("c1_held", cmd_val, 0);
      tick();
    end
    cmd_busy = 0;
    #1;
    chk("c1_cmd_val", cmd_val, 1);
    chk("c1_type", cmd_type, 2);
    chk("c1_port", cmd_port, 5);
    tick();
    chk("c1_pulse_end", cmd_val, 0);
    chk("c1_wait_good", al_done_good_out, 0);
    cmd_done_good = 1;
    tick();
    cmd_done_good = 0;
    chk("c1_good", al_done_good_out, 1);
    chk("c1_bad", al_done_bad_out, 0);
    tick();
    chk("c1_good_held", al_done_good_out, 1);
    al_ack_in = 1;
    tick();
    al_ack_in = 0;
    chk("c1_ack_busy", al_busy_out, 0);
    chk("c1_ack_good", al_done_good_out, 0);
    chk("c1_tout", al_timeout_out, 0);

    // Abort together with TL done_bad, then a strobe ignored in DONE
    al_cmd_val_in = 1;
    al_cmd_type_in = 3'h6;
    al_cmd_port_in = 4'h9;
    tick();
    al_cmd_val_in = 0;
    #1 chk("c2_cmd_val", cmd_val, 1);
    tick();
    al_cmd_abort_in = 1;
    cmd_done_bad = 1;
    tick();
    al_cmd_abort_in = 0;
    cmd_done_bad = 0;
    chk("c2_bad", al_done_bad_out, 1);
    chk("c2_good", al_done_good_out, 0);
    al_cmd_val_in = 1;
    al_cmd_type_in = 3'h1;
    al_cmd_port_in = 4'h3;
    tick();
    al_cmd_val_in = 0;
    chk("c2_type_kept", cmd_type, 6);
    chk("c2_port_kept", cmd_port, 9);
    chk("c2_still_done", al_busy_out, 1);
    #1 chk("c2_no_reissue", cmd_val, 0);
    al_ack_in = 1;
    tick();
    al_ack_in = 0;
    chk("c2_idle", al_busy_out, 0);

    // Abort beats done_good in WAIT
    al_cmd_val_in = 1;
    tick();
    al_cmd_val_in = 0;
    tick();
    al_cmd_abort_in = 1;
    cmd_done_good = 1;
    tick();
    al_cmd_abort_in = 0;
    cmd_done_good = 0;
    chk("c3_bad", al_done_bad_out, 1);
    chk("c3_good", al_done_good_out, 0);
    al_ack_in = 1;
    tick();
    al_ack_in = 0;

    // Abort while TL is busy in ISSUE
    cmd_busy = 1;
    al_cmd_val_in = 1;
    tick();
    al_cmd_val_in = 0;
    al_cmd_abort_in = 1;
    tick();
    al_cmd_abort_in = 0;
    cmd_busy = 0;
    chk("c4_bad", al_done_bad_out, 1);
    al_ack_in = 1;
    tick();
    al_ack_in = 0;

    // Fill past full, then drain in order
    for (int i = 0; i < 17; i++) buf_step(1, i, 0, 0, 0);
    chk("b1_full", al_fill_out, 16);
    for (int i = 0; i < 16; i++) buf_step(0, 0, 0, 1, 0);
    buf_step(0, 0, 0, 1, 0);
    cmd_abort_cycle();

    // Push and pop on a full buffer
    for (int i = 0; i < 16; i++) buf_step(1, 32'h100 + i, 0, 0, 0);
    buf_step(1, 32'hABCD, 1, 1, 0);
    chk("b2_fill16", al_fill_out, 16);
    for (int i = 0; i < 16; i++) buf_step(0, 0, 0, 1, 0);

    // Flush with a coincident push
    for (int i = 0; i < 5; i++) buf_step(1, 32'h200 + i, 0, 0, 0);
    buf_step(1, 32'h77, 0, 0, 1);
    buf_step(0, 0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      buf_step(($urandom % 4) != 0, $urandom, $urandom % 2, $urandom % 2,
               ($urandom % 40) == 0);
    for (int i = 0; i < 20; i++) buf_step(0, 0, 0, 1, 0);
    cmd_abort_cycle();

`ifdef CMD_DBUF_TIMEOUT_EN
    al_cmd_val_in = 1;
    tick();
    al_cmd_val_in = 0;
    tick();
    lat = 0;
    while (!al_done_bad_out && lat < 20) begin
      tick();
      lat++;
    end
    chk("to_latency_ok", (lat == 15) || (lat == 16), 1);
    chk("to_flag", al_timeout_out, 1);
    chk("to_good", al_done_good_out, 0);
    al_ack_in = 1;
    tick();
    al_ack_in = 0;
    chk("to_cleared", al_timeout_out, 0);
`else
    lat = 0;
`endif

    // Reset mid-WAIT with data stored
    al_cmd_val_in = 1;
    al_cmd_type_in = 3'h5;
    al_cmd_port_in = 4'hA;
    tick();
    al_cmd_val_in = 0;
    for (int i = 0; i < 3; i++) buf_step(1, 32'h300 + i, 1, 0, 0);
    for (int i = 0; i < 15; i++) buf_step(1, 32'h400 + i, 0, 0, 0);
    rst = 1;
    mq.delete();
    movf = 0;
    tick();
    rst = 0;
    chk("r_busy", al_busy_out, 0);
    chk("r_bad", al_done_bad_out, 0);
    chk("r_type", cmd_type, 0);
    chk("r_port", cmd_port, 0);
    chk("r_cmd_val", cmd_val, 0);
    chk("r_fill", al_fill_out, 0);
    chk("r_ovf", al_overflow_out, 0);
    chk("r_tl_busy", tl_data_busy_out, 0);
    buf_step(0, 0, 0, 1, 0);
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
